// File: rtl/alu_mul_seq.sv
// Multi-cycle 16-bit shift-and-add multiplier that borrows the shared ALU
// for every add and shift, giving a fixed 33-cycle start-to-done latency.
module alu_mul_seq #(
  parameter logic [2:0] OP_ADD  = 3'd0,
  parameter logic [2:0] OP_LSHF = 3'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_op,
  output logic [3:0]  alu_shift,
  input  logic [15:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = (cnt_q == 5'd15) ? DONE : ADD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The ADD slot is consumed even when the multiplier bit is zero.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = 16'd0;
          cnt_d    = 5'd0;
        end
      end
      ADD: begin
        if (mplier_q[0]) acc_d = alu_out;
      end
      SHIFT: begin
        mcand_d  = alu_out;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd15) product_d = acc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= 16'd0;
      mplier_q  <= 16'd0;
      acc_q     <= 16'd0;
      cnt_q     <= 5'd0;
      product_q <= 16'd0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    alu_in1   = 16'd0;
    alu_in2   = 16'd0;
    alu_op    = OP_ADD;
    alu_shift = 4'd0;
    case (state_q)
      ADD: begin
        busy    = 1'b1;
        alu_in1 = acc_q;
        alu_in2 = mcand_q;
      end
      SHIFT: begin
        busy      = 1'b1;
        alu_in1   = mcand_q;
        alu_op    = OP_LSHF;
        alu_shift = 4'd1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Flags come from the registered product so exactly one is always set.
  assign product = product_q;
  assign n       = product_q[15];
  assign z       = (product_q == 16'd0);
  assign p       = !product_q[15] && (product_q != 16'd0);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural ALU closing the loop.
module tb_alu_mul_seq;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_LSHF = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, n, z, p;
  logic [15:0] product;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_op;
  logic [3:0]  alu_shift;

  typedef struct {
    logic [15:0] prod;
    int          doneCycle;
  } expItem_t;

  expItem_t sb[$];
  int checkCount = 0;
  int errorCount = 0;
  int cycleCnt = 0;
  int activeStart = -1000;

  alu_mul_seq #(.OP_ADD(OP_ADD), .OP_LSHF(OP_LSHF)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .n(n), .z(z), .p(p),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_shift(alu_shift), .alu_out(alu_out)
  );

  // Reference ALU: purely combinational, same encodings as the sequencer parameters.
  always_comb begin
    alu_out = 16'd0;
    case (alu_op)
      OP_ADD:  alu_out = alu_in1 + alu_in2;
      OP_LSHF: alu_out = alu_in1 << alu_shift;
      default: alu_out = 16'd0;
    endcase
  end

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycleCnt);
    end
  endtask

  // Per-cycle protocol checks plus scoreboard pop when a result appears.
  always @(negedge clk) begin
    if (!reset) begin
      logic expBusy, expDone;
      expBusy = (cycleCnt >= activeStart + 1) && (cycleCnt <= activeStart + 32);
      expDone = (cycleCnt == activeStart + 33);
      checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      checkOutput("flagsOneHot", 32'(n) + 32'(z) + 32'(p), 32'd1);
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedDone", 32'd1, 32'd0);
        end else begin
          expItem_t e;
          e = sb.pop_front();
          checkOutput("doneCycle", cycleCnt, e.doneCycle);
          checkOutput("product", {16'd0, product}, {16'd0, e.prod});
          checkOutput("n", {31'd0, n}, {31'd0, e.prod[15]});
          checkOutput("z", {31'd0, z}, {31'd0, e.prod == 16'd0});
          checkOutput("p", {31'd0, p}, {31'd0, !e.prod[15] && e.prod != 16'd0});
          checkOutput("doneAluOp", {29'd0, alu_op}, {29'd0, OP_ADD});
          checkOutput("doneAluIn1", {16'd0, alu_in1}, 32'd0);
        end
      end
    end
  end

  task automatic gotoCycle(input int c);
    while (cycleCnt < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a one-cycle start in the current cycle; returns in the following cycle.
  task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn, input bit expectAccept);
    expItem_t e;
    logic [15:0] prod;
    a = aIn;
    b = bIn;
    start = 1'b1;
    if (expectAccept) begin
      prod = aIn * bIn;
      e.prod = prod;
      e.doneCycle = cycleCnt + 33;
      activeStart = cycleCnt;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic waitDrain();
    int budget;
    budget = 80;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (sb.size() != 0) begin
      checkOutput("drainTimeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  int s;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = 16'd0;
    b = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstProduct", {16'd0, product}, 32'd0);
    checkOutput("rstZ", {31'd0, z}, 32'd1);
    checkOutput("rstN", {31'd0, n}, 32'd0);
    checkOutput("rstP", {31'd0, p}, 32'd0);
    checkOutput("rstAluOp", {29'd0, alu_op}, {29'd0, OP_ADD});
    checkOutput("rstAluShift", {28'd0, alu_shift}, 32'd0);
    checkOutput("rstAluIn2", {16'd0, alu_in2}, 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(16'd15, 16'd37, 1'b1);
    waitDrain();
    checkOutput("holdProduct", {16'd0, product}, 32'd555);
    applyStimulus(16'hFFFF, 16'h0002, 1'b1);
    waitDrain();
    applyStimulus(16'h0100, 16'h0100, 1'b1);
    waitDrain();

    // Back-to-back at the minimum issue interval.
    s = cycleCnt;
    applyStimulus(16'd0, 16'h1234, 1'b1);
    gotoCycle(s + 34);
    applyStimulus(16'd3, 16'hFFFF, 1'b1);
    waitDrain();

    // A start during the busy window must be dropped.
    s = cycleCnt;
    applyStimulus(16'd7, 16'd9, 1'b1);
    gotoCycle(s + 10);
    applyStimulus(16'd2, 16'd2, 1'b0);
    waitDrain();
    checkOutput("ignoredStart", {16'd0, product}, 32'd63);

    // Reset mid-operation aborts without a done pulse.
    s = cycleCnt;
    applyStimulus(16'd5, 16'd5, 1'b1);
    gotoCycle(s + 12);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    activeStart = -1000;
    sb.delete();
    @(negedge clk);
    checkOutput("abortProduct", {16'd0, product}, 32'd0);
    checkOutput("abortZ", {31'd0, z}, 32'd1);
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    gotoCycle(s + 14);
    applyStimulus(16'd5, 16'd5, 1'b1);
    waitDrain();

    // Reset and start together: reset wins.
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rstStartBusy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'b1);
      waitDrain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
